// File: rtl/rr_prio_arbiter.sv
// rr_prio_arbiter
//   Two-level round-robin arbiter for num_master requesters of one shared
//   resource. Requesters flagged high priority are served first, and ties at
//   each level rotate round-robin. The owner keeps the grant until one of
//   these happens:
//     - it releases the resource;
//     - a high-priority requester preempts a low-priority owner;
//     - its tenure of max_hold cycles runs out while someone else waits.
//   The grant is registered, so it appears one edge after the request.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (0 = reset)
//   req          per-master request, level sensitive
//   pri          per-master high-priority flag, only meaningful with req
//   grant        registered one-hot grant, or all zero
//   grant_id     encoded index of the granted master, 0 when none
//   grant_valid  high whenever any grant bit is set
module rr_prio_arbiter #(
  parameter int num_master = 4,
  parameter int max_hold   = 8,
  parameter int id_w       = $clog2(num_master)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [num_master-1:0] req,
  input  logic [num_master-1:0] pri,
  output logic [num_master-1:0] grant,
  output logic [id_w-1:0]       grant_id,
  output logic                  grant_valid
);

  // Wide enough to hold the saturated value max_hold.
  localparam int cnt_w = $clog2(max_hold + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t                state_q,    state_d;
  logic [num_master-1:0] grant_q,    grant_d;
  logic [id_w-1:0]       grant_id_q, grant_id_d;
  logic [id_w-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [cnt_w-1:0]      hold_cnt_q, hold_cnt_d;

  // Re-arbitration triggers for the current owner.
  logic [num_master-1:0] others_req;
  logic                  owner_release;
  logic                  owner_preempt;
  logic                  owner_expire;

  // Arbitration datapath.
  logic [num_master-1:0] arb_req;
  logic [num_master-1:0] arb_pri_req;
  logic [num_master-1:0] cand;
  logic                  win_found;
  logic [id_w-1:0]       win_idx;
  logic [num_master-1:0] win_onehot;
  logic [id_w-1:0]       win_next_ptr;
  int                    scan_idx;

  // ---------------------------------------------------------------------
  // Owner status
  // ---------------------------------------------------------------------
  // In IDLE grant_q is zero, so others_req is simply req.
  assign others_req    = req & ~grant_q;
  assign owner_release = !req[grant_id_q];
  // Only a low-priority owner can be preempted, and only by a high-priority
  // requester other than itself.
  assign owner_preempt = !pri[grant_id_q] && (|(others_req & pri));
  // Tenure ends on the edge that would start cycle max_hold+1. A lone
  // requester is never re-granted through expiry; its counter just stays
  // saturated.
  assign owner_expire  = (int'(hold_cnt_q) >= max_hold - 1) && (|others_req);

  // ---------------------------------------------------------------------
  // Candidate selection
  // ---------------------------------------------------------------------
  // The owner is masked before the priority split. This lets a
  // high-priority owner whose tenure expired hand over to low-priority
  // waiters. On a release, the owner has no request anyway.
  assign arb_req     = (state_q == OWN) ? others_req : req;
  assign arb_pri_req = arb_req & pri;
  assign cand        = (|arb_pri_req) ? arb_pri_req : arb_req;

  // Round-robin scan: first set candidate at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < num_master; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= num_master) begin
        scan_idx = scan_idx - num_master;
      end
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = id_w'(scan_idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < num_master; gi++) begin : g_win_onehot
      assign win_onehot[gi] = win_found && (win_idx == id_w'(gi));
    end
  endgenerate

  // The next search starts just past the winner.
  assign win_next_ptr = (win_idx == id_w'(num_master - 1)) ? '0 : win_idx + id_w'(1);

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = OWN;
          grant_d    = win_onehot;
          grant_id_d = win_idx;
          rr_ptr_d   = win_next_ptr;
          hold_cnt_d = '0;
        end
      end
      OWN: begin
        if (int'(hold_cnt_q) < max_hold) begin
          hold_cnt_d = hold_cnt_q + cnt_w'(1);
        end
        if (owner_release || owner_preempt || owner_expire) begin
          if (win_found) begin
            grant_d    = win_onehot;
            grant_id_d = win_idx;
            rr_ptr_d   = win_next_ptr;
            hold_cnt_d = '0;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            hold_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = |grant_q;

  // ---------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------
  ast_grant_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant_q));

  ast_grant_had_req: assert property (@(posedge clk) disable iff (!rst)
    (grant_q & ~$past(req)) == '0);

  ast_grant_id_match: assert property (@(posedge clk) disable iff (!rst)
    (|grant_q) ? (grant_q[grant_id_q] == 1'b1) : (grant_id_q == '0));

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Testbench for rr_prio_arbiter (num_master=4, max_hold=4).
// Every driven transaction pushes its expected grant onto a scoreboard queue.
// The owning scenario task pops that entry and compares it just after the
// edge that produces the grant.
module tb_rr_prio_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] pri;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
  } exp_t;

  exp_t exp_q[$];

  rr_prio_arbiter #(
    .num_master(4),
    .max_hold  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pri        (pri),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (g[k]) r = 2'(k);
    end
    return r;
  endfunction

  // Drive req/pri on the falling edge, record the expected grant for the
  // following rising edge, then return just after that edge.
  task automatic drive(input logic [3:0] r, input logic [3:0] p, input logic [3:0] eg);
    exp_t e;
    @(negedge clk);
    req = r;
    pri = p;
    e.g  = eg;
    e.id = enc(eg);
    e.v  = |eg;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    pri = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    pri = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: grant=%b id=%0d valid=%b, want 0000/0/0", grant, grant_id, grant_valid);
    end else begin
      $display("reset_hold grant=%b id=%0d valid=%b", grant, grant_id, grant_valid);
    end
    @(negedge clk);
    req = 4'b0000;
    pri = 4'b0000;
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] r_t [4] = '{4'b0000, 4'b0110, 4'b0000, 4'b0110};
    logic [3:0] g_t [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100};
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(r_t[i], 4'b0000, g_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v) begin
        errors++;
        $display("FAIL round_robin step %0d: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                 i, grant, grant_id, grant_valid, e.g, e.id, e.v);
      end else begin
        $display("round_robin step %0d req=%b grant=%b id=%0d", i, req, grant, grant_id);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] r_t [5] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
    logic [3:0] p_t [5] = '{4'b0100, 4'b0010, 4'b0010, 4'b0110, 4'b0000};
    logic [3:0] g_t [5] = '{4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(r_t[i], p_t[i], g_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v) begin
        errors++;
        $display("FAIL priority step %0d: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                 i, grant, grant_id, grant_valid, e.g, e.id, e.v);
      end else begin
        $display("priority step %0d req=%b pri=%b grant=%b id=%0d", i, req, pri, grant, grant_id);
      end
    end
  endtask

  task automatic test_tenure();
    logic [3:0] eg;
    exp_t e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      eg = ((i / 4) % 2 == 0) ? 4'b0010 : 4'b0100;
      drive(4'b0110, 4'b0000, eg);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v) begin
        errors++;
        $display("FAIL tenure cycle %0d: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                 i, grant, grant_id, grant_valid, e.g, e.id, e.v);
      end else begin
        $display("tenure cycle %0d req=%b grant=%b id=%0d", i, req, grant, grant_id);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] r_t [4] = '{4'b0010, 4'b1001, 4'b0000, 4'b0000};
    logic [3:0] g_t [4] = '{4'b0010, 4'b1000, 4'b0000, 4'b0000};
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(r_t[i], 4'b0000, g_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v) begin
        errors++;
        $display("FAIL release step %0d: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                 i, grant, grant_id, grant_valid, e.g, e.id, e.v);
      end else begin
        $display("release step %0d req=%b grant=%b id=%0d", i, req, grant, grant_id);
      end
    end
  endtask

  task automatic test_lone_owner();
    logic [3:0] r;
    logic [3:0] eg;
    exp_t e;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      // 20 cycles alone, then master 1 joins. Master 1 takes over at once
      // (saturated tenure), keeps it for 4 cycles, then master 0 regains it.
      r  = (i < 20) ? 4'b0001 : 4'b0011;
      eg = (i < 20) ? 4'b0001 : ((i < 24) ? 4'b0010 : 4'b0001);
      drive(r, 4'b0000, eg);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v) begin
        errors++;
        $display("FAIL lone_owner cycle %0d: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                 i, grant, grant_id, grant_valid, e.g, e.id, e.v);
      end else begin
        $display("lone_owner cycle %0d req=%b grant=%b id=%0d", i, req, grant, grant_id);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] g_t [3] = '{4'b0100, 4'b0100, 4'b0010};
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        // Reset drops between edges: outputs must clear without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
          errors++;
          $display("FAIL async_reset_immediate: grant=%b id=%0d valid=%b, want 0000/0/0",
                   grant, grant_id, grant_valid);
        end else begin
          $display("async_reset_immediate grant=%b valid=%b", grant, grant_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_id !== 2'd0 || grant_valid !== 1'b0) begin
          errors++;
          $display("FAIL async_reset_held: grant=%b id=%0d valid=%b, want 0000/0/0",
                   grant, grant_id, grant_valid);
        end else begin
          $display("async_reset_held grant=%b valid=%b", grant, grant_valid);
        end
        rst = 1'b1;
      end
      drive((i == 0) ? 4'b0100 : 4'b0110, 4'b0000, g_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.g || grant_id !== e.id || grant_valid !== e.v) begin
        errors++;
        $display("FAIL async_reset step %0d: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
                 i, grant, grant_id, grant_valid, e.g, e.id, e.v);
      end else begin
        $display("async_reset step %0d req=%b grant=%b id=%0d", i, req, grant, grant_id);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b0000;
    pri = 4'b0000;
    test_reset();
    test_round_robin();
    test_priority();
    test_tenure();
    test_release();
    test_lone_owner();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
